// File: rtl/fallthrough_small_fifo_old.sv
// Small fall-through FIFO: the head word is visible on dout as soon as it is stored.
// Optional macro SMALL_FIFO_CHECKS_EN adds simulation-only overflow/underflow messages.
module fallthrough_small_fifo_old #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 3,
    parameter int NEARLY_FULL    = 2**MAX_DEPTH_BITS - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             nearly_full,
    output logic             empty
);

    localparam int DEPTH = 2**MAX_DEPTH_BITS;
    localparam logic [MAX_DEPTH_BITS:0]   DEPTH_CNT = (MAX_DEPTH_BITS+1)'(DEPTH);
    localparam logic [MAX_DEPTH_BITS:0]   NF_CNT    = (MAX_DEPTH_BITS+1)'(NEARLY_FULL);
    localparam logic [MAX_DEPTH_BITS:0]   CNT_ONE   = (MAX_DEPTH_BITS+1)'(1);
    localparam logic [MAX_DEPTH_BITS-1:0] PTR_ONE   = MAX_DEPTH_BITS'(1);

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [MAX_DEPTH_BITS:0]   count_q, count_d;
    logic                      wr_accept;
    logic                      rd_accept;

    // A full FIFO refuses writes even when a pop happens in the same cycle.
    always_comb begin
        wr_accept = reset && wr_en && !full;
        rd_accept = reset && rd_en && !empty;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left out of reset; the count alone defines validity.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_q] <= din;
        end
    end

    assign empty       = (count_q == '0);
    assign full        = (count_q == DEPTH_CNT);
    assign nearly_full = (count_q >= NF_CNT);
    assign dout        = empty ? '0 : mem[rd_ptr_q];

`ifdef SMALL_FIFO_CHECKS_EN
    always @(posedge clk) begin
        if (reset && wr_en && full) begin
            $error("fallthrough_small_fifo_old: write while full");
        end
        if (reset && rd_en && empty) begin
            $error("fallthrough_small_fifo_old: read while empty");
        end
    end
`else
    // Default build carries no simulation messages.
`endif

endmodule

// File: tb/tb_fallthrough_small_fifo_old.sv
// Self-checking bench for fallthrough_small_fifo_old: directed scenarios plus a random
// phase, all compared against a queue-based reference model.
module tb_fallthrough_small_fifo_old;

    localparam int WIDTH = 72;
    localparam int DEPTH = 8;
    localparam int NF    = 7;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] din;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] dout;
    logic             full;
    logic             nearly_full;
    logic             empty;

    int errors = 0;
    int checks = 0;
    logic [WIDTH-1:0] model_q[$];

    fallthrough_small_fifo_old dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .dout       (dout),
        .full       (full),
        .nearly_full(nearly_full),
        .empty      (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected outputs come only from the occupancy and order of the model queue.
    task automatic check_output(input string tag);
        logic [WIDTH-1:0] head;
        head = (model_q.size() > 0) ? model_q[0] : '0;
        check({tag, " dout"}, dout, head);
        check({tag, " empty"}, WIDTH'(empty), WIDTH'(model_q.size() == 0));
        check({tag, " full"}, WIDTH'(full), WIDTH'(model_q.size() == DEPTH));
        check({tag, " nearly_full"}, WIDTH'(nearly_full), WIDTH'(model_q.size() >= NF));
    endtask

    task automatic apply_stimulus(input string tag, input logic w, input logic r, input logic [WIDTH-1:0] d);
        bit w_ok;
        bit r_ok;
        @(negedge clk);
        wr_en = w;
        rd_en = r;
        din   = d;
        @(posedge clk);
        if (reset) begin
            w_ok = w && (model_q.size() < DEPTH);
            r_ok = r && (model_q.size() > 0);
            if (r_ok) void'(model_q.pop_front());
            if (w_ok) model_q.push_back(d);
        end
        #1;
        check_output(tag);
    endtask

    initial begin
        reset = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;

        // Requests during reset must be ignored.
        apply_stimulus("in_reset_wr", 1'b1, 1'b0, 72'h11);
        apply_stimulus("in_reset_rd", 1'b1, 1'b1, 72'h22);
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        reset = 1'b1;
        #1;
        check_output("after_release");

        apply_stimulus("wr_a5", 1'b1, 1'b0, 72'hA5);
        check("wr_a5 const", dout, 72'hA5);
        apply_stimulus("rd_a5", 1'b0, 1'b1, '0);
        check("rd_a5 const", dout, '0);

        for (int i = 1; i <= 8; i++) begin
            apply_stimulus($sformatf("fill_%0d", i), 1'b1, 1'b0, WIDTH'(i));
        end
        check("full const", WIDTH'(full), WIDTH'(1));
        apply_stimulus("drop_9", 1'b1, 1'b0, 72'h9);
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("pop_val_%0d", i), dout, WIDTH'(i));
            apply_stimulus($sformatf("pop_%0d", i), 1'b0, 1'b1, '0);
        end

        apply_stimulus("wrap_prime", 1'b1, 1'b0, 72'h0);
        for (int i = 1; i < 20; i++) begin
            check($sformatf("wrap_head_%0d", i - 1), dout, WIDTH'(i - 1));
            apply_stimulus($sformatf("wrap_%0d", i), 1'b1, 1'b1, WIDTH'(i));
        end
        check("wrap_head_19", dout, WIDTH'(19));
        apply_stimulus("wrap_drain", 1'b0, 1'b1, '0);

        for (int i = 0; i < 8; i++) begin
            apply_stimulus($sformatf("refill_%0d", i), 1'b1, 1'b0, WIDTH'(8'h40 + i));
        end
        apply_stimulus("wr_rd_full", 1'b1, 1'b1, 72'hEE);
        check("wr_rd_full size", WIDTH'(model_q.size()), WIDTH'(7));
        check("wr_rd_full flag", WIDTH'(full), '0);
        for (int i = 0; i < 7; i++) begin
            apply_stimulus($sformatf("drain_%0d", i), 1'b0, 1'b1, '0);
        end
        apply_stimulus("wr_rd_empty", 1'b1, 1'b1, 72'h77);
        check("wr_rd_empty dout", dout, 72'h77);
        apply_stimulus("wr_rd_empty_pop", 1'b0, 1'b1, '0);

        for (int i = 0; i < 300; i++) begin
            apply_stimulus($sformatf("rand_%0d", i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           {8'($urandom), $urandom, $urandom});
        end

        while (model_q.size() > 0) begin
            apply_stimulus("pre_reset_drain", 1'b0, 1'b1, '0);
        end
        for (int i = 0; i < 3; i++) begin
            apply_stimulus($sformatf("hold_%0d", i), 1'b1, 1'b0, WIDTH'(8'hC0 + i));
        end
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        reset = 1'b0;
        model_q.delete();
        #1;
        check_output("mid_reset");
        apply_stimulus("mid_reset_wr", 1'b1, 1'b0, 72'h55);
        @(negedge clk);
        wr_en = 1'b0;
        reset = 1'b1;
        apply_stimulus("post_reset_3c", 1'b1, 1'b0, 72'h3C);
        check("post_reset_3c const", dout, 72'h3C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fallthrough_small_fifo_old.md
FALLTHROUGH_SMALL_FIFO_OLD -- requirements
Module: fallthrough_small_fifo_old

Interface
REQ-001 SHALL have parameter WIDTH, default 72, data word width in bits.
REQ-002 SHALL have parameter MAX_DEPTH_BITS, default 3, log2 of depth; DEPTH = 2**MAX_DEPTH_BITS (8 by default).
REQ-003 SHALL have parameter NEARLY_FULL, default 2**MAX_DEPTH_BITS-1, occupancy at or above which nearly_full asserts.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset is asynchronous and active-low.
REQ-006 SHALL have port din, input, WIDTH bits: write data.
REQ-007 SHALL have port wr_en, input, 1 bit: write request, sampled on the rising edge.
REQ-008 SHALL have port rd_en, input, 1 bit: pop request for the word currently on dout.
REQ-009 SHALL have port dout, output, WIDTH bits: head-of-queue word (fall-through, no read latency).
REQ-010 SHALL have port full, output, 1 bit: occupancy == DEPTH.
REQ-011 SHALL have port nearly_full, output, 1 bit: occupancy >= NEARLY_FULL.
REQ-012 SHALL have port empty, output, 1 bit: occupancy == 0.

Function
REQ-013 SHALL store up to DEPTH words in strict FIFO order.
REQ-014 SHALL use MAX_DEPTH_BITS-wide write/read pointers that wrap from DEPTH-1 to 0, and a MAX_DEPTH_BITS+1-bit occupancy count.
REQ-015 SHALL accept a write on a rising edge when wr_en=1 and full=0: store din at write pointer, advance pointer.
REQ-016 SHALL ignore wr_en while full=1, even with rd_en=1 the same cycle; no storage, pointer or count change.
REQ-017 SHALL accept a pop on a rising edge when rd_en=1 and empty=0: advance read pointer.
REQ-018 SHALL ignore rd_en while empty=1; a simultaneous write is still accepted and count becomes 1.
REQ-019 SHALL, on simultaneous accepted write and pop, advance both pointers and leave count unchanged.
REQ-020 SHALL present the head word on dout combinationally from storage whenever empty=0; a word written at edge k is on dout, with empty=0, immediately after edge k (1-cycle write-to-visible latency).
REQ-021 SHALL drive dout to all zeros while empty=1.
REQ-022 SHALL update the head word on dout immediately after the edge that accepts a pop.
REQ-023 SHALL derive full, nearly_full and empty solely from the occupancy count, glitch-free after each edge.

Reset
REQ-024 SHALL, when reset is low, asynchronously clear both pointers and the count to 0, giving empty=1, full=0, nearly_full=0 and dout=0.
REQ-025 SHALL ignore wr_en and rd_en while reset is low; storage contents need not be cleared.
REQ-026 SHALL treat a reset assertion mid-operation as discarding all queued words; the first write after release appears at dout.

Configuration
REQ-027 SHALL, when macro SMALL_FIFO_CHECKS_EN is defined, print a simulation error message on each rising edge with wr_en=1 while full=1 and with rd_en=1 while empty=1; checks are excluded from synthesis.
REQ-028 SHALL, without SMALL_FIFO_CHECKS_EN, produce no messages; data-path behaviour is identical in both builds.

Verification
REQ-029 Bench SHALL cover: reset low, then release -> empty=1, full=0, nearly_full=0, dout=0.
REQ-030 Bench SHALL cover: write 0xA5 in one cycle -> after that edge empty=0 and dout=0xA5; rd_en for one cycle -> empty=1, dout=0.
REQ-031 Bench SHALL cover: write 8 words 1..8 -> after the 7th, nearly_full=1; after the 8th, full=1; a 9th write of 9 is dropped; eight pops return 1..8 in order.
REQ-032 Bench SHALL cover: pointer wrap -> 20 interleaved write/pop pairs with values 0..19 return 0..19 with count steady at 1.
REQ-033 Bench SHALL cover: simultaneous wr_en and rd_en when full -> one pop only, count 7, full=0; when empty -> count 1, dout equals new din.
REQ-034 Bench SHALL cover: reset low while holding 3 words -> immediately empty=1; after release, write 0x3C -> dout=0x3C.
